// File: rtl/vx_tensor_result_serializer.sv
// Buffers full 4x4 result tiles with their warp id and drains them to commit
// one row per beat, rows 0..3 in order.

module vx_tensor_result_serializer_lane #(
    parameter int DATA_W = 32
) (
    input  logic                   en,
    input  logic [1:0]             row_sel,
    input  logic [3:0][DATA_W-1:0] col,
    output logic [DATA_W-1:0]      word
);
    assign word = en ? col[row_sel] : '0;
endmodule

module vx_tensor_result_serializer #(
    parameter int WID_W     = 4,
    parameter int BUF_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [3:0][3:0][31:0]   D_tile,
    input  logic [WID_W-1:0]        D_wid,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [3:0][31:0]        out_row,
    output logic [1:0]              out_row_idx,
    output logic [WID_W-1:0]        out_wid,
    output logic                    out_last
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [BUF_DEPTH-1:0][3:0][3:0][31:0] tile_mem;
    logic [BUF_DEPTH-1:0][WID_W-1:0]      wid_mem;
    logic [PTR_W-1:0]                     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]                     count;
    logic [1:0]                           beat;

    logic full, empty, push, fire, pop;
    logic [3:0][3:0][31:0] head_tile;
    logic [3:0][3:0][31:0] head_col;

    assign full  = (count == CNT_W'(BUF_DEPTH));
    assign empty = (count == '0);
    // Enqueue is gated by the registered full flag only, so a same-cycle pop
    // never opens a slot for a tile that was offered while full.
    assign push  = valid_in && !full;
    assign fire  = !empty && ready_out;
    assign pop   = fire && (beat == 2'd3);

    assign ready_in    = !full;
    assign valid_out   = !empty;
    assign out_row_idx = beat;
    assign out_last    = !empty && (beat == 2'd3);
    assign out_wid     = empty ? '0 : wid_mem[rd_ptr];
    assign head_tile   = tile_mem[rd_ptr];

    // Tile payload needs no reset; emptiness masks it on the outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            tile_mem[wr_ptr] <= D_tile;
            wid_mem[wr_ptr]  <= D_wid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            beat   <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (fire)
                beat <= beat + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Column-wise row select: each lane picks its column's word for the current beat.
    for (genvar c = 0; c < 4; c++) begin : g_lane
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign head_col[c][r] = head_tile[r][c];
        end
        vx_tensor_result_serializer_lane #(.DATA_W(32)) u_lane (
            .en      (!empty),
            .row_sel (beat),
            .col     (head_col[c]),
            .word    (out_row[c])
        );
    end
endmodule

// File: tb/tb_vx_tensor_result_serializer.sv
// Directed bench for the tile-to-row serializer: reset, single tile, stalls,
// full buffer, streaming, enqueue/pop overlap and reset mid-drain.

module tb_vx_tensor_result_serializer;
    typedef logic [3:0][3:0][31:0] tile_t;
    typedef logic [3:0][31:0]      row_t;

    logic        clk, reset, valid_in, ready_in, valid_out, ready_out, out_last;
    tile_t       D_tile;
    logic [3:0]  D_wid, out_wid;
    row_t        out_row;
    logic [1:0]  out_row_idx;

    int n_vec = 0;
    int n_err = 0;

    vx_tensor_result_serializer #(.WID_W(4), .BUF_DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .D_tile      (D_tile),
        .D_wid       (D_wid),
        .valid_out   (valid_out),
        .ready_out   (ready_out),
        .out_row     (out_row),
        .out_row_idx (out_row_idx),
        .out_wid     (out_wid),
        .out_last    (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic tile_t mk_tile(input int base);
        tile_t t;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][c] = 32'(base + 16 * r + c);
        return t;
    endfunction

    function automatic row_t mk_row(input int base, input int r);
        row_t w;
        for (int c = 0; c < 4; c++)
            w[c] = 32'(base + 16 * r + c);
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_beat(input string tag, input int base, input int r, input int wid);
        chk({tag, ".valid"}, 128'(valid_out), 128'(1));
        chk({tag, ".idx"},   128'(out_row_idx), 128'(r));
        chk({tag, ".row"},   128'(out_row), 128'(mk_row(base, r)));
        chk({tag, ".wid"},   128'(out_wid), 128'(wid));
        chk({tag, ".last"},  128'(out_last), 128'(r == 3));
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, ".valid"}, 128'(valid_out), 128'(0));
        chk({tag, ".last"},  128'(out_last), 128'(0));
    endtask

    initial begin
        int  nxt, j, cyc;
        bit  started;
        logic acc;

        reset = 1'b1; valid_in = 1'b0; ready_out = 1'b0;
        D_tile = '0; D_wid = '0;
        step(); step();

        // reset state
        chk("rst.valid", 128'(valid_out), 128'(0));
        chk("rst.last",  128'(out_last), 128'(0));
        chk("rst.idx",   128'(out_row_idx), 128'(0));
        chk("rst.ready", 128'(ready_in), 128'(1));
        chk("rst.row",   128'(out_row), 128'(0));
        chk("rst.wid",   128'(out_wid), 128'(0));

        // single tile offered in the first cycle after reset release
        reset = 1'b0; ready_out = 1'b1;
        valid_in = 1'b1; D_tile = mk_tile(0); D_wid = 4'd3;
        chk("single.nocomb", 128'(valid_out), 128'(0));
        step();
        valid_in = 1'b0; D_tile = '1; D_wid = 4'hf;
        for (int r = 0; r < 4; r++) begin
            expect_beat("single", 0, r, 3);
            step();
        end
        expect_idle("single.end");

        // backpressure: each beat held across a stalled cycle
        valid_in = 1'b1; D_tile = mk_tile(100); D_wid = 4'd5;
        step();
        valid_in = 1'b0;
        for (int r = 0; r < 4; r++) begin
            ready_out = 1'b0;
            expect_beat("bp.pre", 100, r, 5);
            step();
            expect_beat("bp.held", 100, r, 5);
            ready_out = 1'b1;
            step();
        end
        expect_idle("bp.end");

        // full buffer: third tile waits for the first tile's last beat
        ready_out = 1'b0;
        valid_in = 1'b1; D_tile = mk_tile(300); D_wid = 4'd1;
        step();
        chk("full.rdy_one", 128'(ready_in), 128'(1));
        D_tile = mk_tile(400); D_wid = 4'd2;
        step();
        chk("full.rdy_two", 128'(ready_in), 128'(0));
        D_tile = mk_tile(500); D_wid = 4'd4;
        step();
        chk("full.rdy_held", 128'(ready_in), 128'(0));
        expect_beat("full.A", 300, 0, 1);
        ready_out = 1'b1;
        for (int r = 1; r < 4; r++) begin
            step();
            expect_beat("full.A", 300, r, 1);
        end
        chk("full.rdy_at_last", 128'(ready_in), 128'(0));
        step();
        chk("full.rdy_after_pop", 128'(ready_in), 128'(1));
        expect_beat("full.B", 400, 0, 2);
        step();
        valid_in = 1'b0;
        for (int r = 1; r < 4; r++) begin
            expect_beat("full.B", 400, r, 2);
            step();
        end
        for (int r = 0; r < 4; r++) begin
            expect_beat("full.C", 500, r, 4);
            step();
        end
        expect_idle("full.end");

        // streaming: four tiles back-to-back, 16 beats without a gap
        ready_out = 1'b1;
        valid_in = 1'b1; D_tile = mk_tile(200); D_wid = 4'd0;
        nxt = 0; j = 0; cyc = 0; started = 1'b0;
        while (j < 16 && cyc < 60) begin
            acc = valid_in && ready_in;
            step();
            cyc++;
            if (acc) begin
                nxt++;
                if (nxt < 4) begin
                    D_tile = mk_tile(200 + 64 * nxt);
                    D_wid  = 4'(nxt);
                end else begin
                    valid_in = 1'b0;
                end
            end
            if (valid_out) begin
                started = 1'b1;
                expect_beat("stream", 200 + 64 * (j / 4), j % 4, j / 4);
                j++;
            end else if (started) begin
                chk("stream.gap", 128'(valid_out), 128'(1));
            end
        end
        chk("stream.count", 128'(j), 128'(16));
        step();
        expect_idle("stream.end");

        // enqueue coincides with the last beat of the only buffered tile
        valid_in = 1'b1; D_tile = mk_tile(600); D_wid = 4'd6;
        step();
        valid_in = 1'b0;
        for (int r = 0; r < 3; r++) begin
            expect_beat("sim.X", 600, r, 6);
            step();
        end
        expect_beat("sim.X", 600, 3, 6);
        valid_in = 1'b1; D_tile = mk_tile(700); D_wid = 4'd7;
        step();
        valid_in = 1'b0;
        for (int r = 0; r < 4; r++) begin
            expect_beat("sim.Y", 700, r, 7);
            step();
        end
        expect_idle("sim.end");

        // reset mid-drain discards the partial tile
        valid_in = 1'b1; D_tile = mk_tile(800); D_wid = 4'd9;
        step();
        valid_in = 1'b0;
        expect_beat("mid.Z", 800, 0, 9);
        step();
        expect_beat("mid.Z", 800, 1, 9);
        step();
        expect_beat("mid.Z", 800, 2, 9);
        #2 reset = 1'b1;
        #1;
        chk("mid.rst.valid", 128'(valid_out), 128'(0));
        chk("mid.rst.ready", 128'(ready_in), 128'(1));
        chk("mid.rst.idx",   128'(out_row_idx), 128'(0));
        chk("mid.rst.row",   128'(out_row), 128'(0));
        chk("mid.rst.wid",   128'(out_wid), 128'(0));
        chk("mid.rst.last",  128'(out_last), 128'(0));
        step(); step();
        reset = 1'b0;
        valid_in = 1'b1; D_tile = mk_tile(900); D_wid = 4'd10;
        step();
        valid_in = 1'b0;
        for (int r = 0; r < 4; r++) begin
            expect_beat("mid.W", 900, r, 10);
            step();
        end
        expect_idle("mid.end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
